// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared widths, stall patterns and FSM encodings for the pipeline sequencer
package pipe_ctrl_pkg;
  localparam int STALL_W = 6;
  localparam int STALL_PC = 0;
  localparam int STALL_IF = 1;
  localparam int STALL_ID = 2;
  localparam int STALL_EX = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB = 5;
  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_BY_ID = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_BY_EX = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_BY_MEM = 6'b011111;
  localparam logic [31:0] TRAP_VEC_DEF = 32'h0000_0100;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } mem_state_e;
endpackage

// File: rtl/pipe_ctrl_mem_wait_fsm.sv
// mem_wait_fsm: MEM-stage bus-wait FSM with timeout counter
//   in : clk, rst (async, active-high), mem_req, mem_ack
//   out: memstall (MEM access pending, hold pipe), err (one cycle in ERR state)
module mem_wait_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int TMO_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req,
  input  logic mem_ack,
  output logic memstall,
  output logic err
);
  localparam logic [7:0] TMO_LAST = 8'(TMO_CYCLES - 1);
  mem_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  // a dropped mem_req in WAIT is ignored: only ack or timeout leaves WAIT
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      S_IDLE: begin
        state_d = (mem_req & !mem_ack) ? S_WAIT : S_IDLE;
        cnt_d = (mem_req & !mem_ack) ? 8'd1 : 8'd0;
      end
      S_WAIT: begin
        state_d = mem_ack ? S_IDLE : (cnt_q == TMO_LAST) ? S_ERR : S_WAIT;
        cnt_d = mem_ack ? 8'd0 : cnt_q + 8'd1;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d = 8'd0;
      end
    endcase
  end
  always_comb begin
    memstall = (state_q == S_WAIT) | ((state_q == S_IDLE) & mem_req & !mem_ack);
    err = (state_q == S_ERR);
  end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencer merging stall requests, branch flush/redirect and bus-timeout trap
//   in : clk, rst (async, active-high), stallreq_id, stallreq_ex, mem_req, mem_ack,
//        branch_flag_i, branch_target_i[31:0]
//   out: stall[5:0] (pc,if,id,ex,mem,wb hold), flush, new_pc[31:0], mem_err
//   PIPE_PERF_EN adds stall_cnt[31:0] and flush_cnt[31:0] performance counters
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TMO_CYCLES = 16,
  parameter logic [31:0] TRAP_VEC = TRAP_VEC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        mem_req,
  input  logic        mem_ack,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        mem_err
`ifdef PIPE_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);
  logic memstall, br_take;
  mem_wait_fsm #(.TMO_CYCLES(TMO_CYCLES)) u_mem_wait_fsm (
    .clk(clk),
    .rst(rst),
    .mem_req(mem_req),
    .mem_ack(mem_ack),
    .memstall(memstall),
    .err(mem_err)
  );
  // a branch is only taken when EX is not held; an ID stall yields to the flush
  // because the stalling instruction is squashed anyway
  always_comb begin
    br_take = branch_flag_i & !(memstall | stallreq_ex);
    stall = mem_err ? STALL_NONE :
            memstall ? STALL_BY_MEM :
            stallreq_ex ? STALL_BY_EX :
            (stallreq_id & !br_take) ? STALL_BY_ID : STALL_NONE;
    flush = mem_err | br_take;
    new_pc = mem_err ? TRAP_VEC : br_take ? branch_target_i : 32'h0;
  end
`ifdef PIPE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, stall[STALL_PC]};
    flush_cnt_d = flush_cnt_q + {31'd0, flush};
  end
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl with TMO_CYCLES=4
module tb_pipe_ctrl;
  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        err;
  } exp_t;
  logic clk, rst, stallreq_id, stallreq_ex, mem_req, mem_ack, branch_flag_i;
  logic [31:0] branch_target_i, new_pc;
  logic [5:0] stall;
  logic flush, mem_err;
`ifdef PIPE_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif
  exp_t exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  pipe_ctrl #(.TMO_CYCLES(4), .TRAP_VEC(32'h0000_0100)) dut (
    .clk(clk),
    .rst(rst),
    .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex),
    .mem_req(mem_req),
    .mem_ack(mem_ack),
    .branch_flag_i(branch_flag_i),
    .branch_target_i(branch_target_i),
    .stall(stall),
    .flush(flush),
    .new_pc(new_pc),
    .mem_err(mem_err)
`ifdef PIPE_PERF_EN
    ,
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // drive one cycle of stimulus, queue its expected outputs, then compare mid-cycle
  task automatic step(input string tag, input logic r, input logic id, input logic ex,
                      input logic req, input logic ack, input logic br, input logic [31:0] tgt,
                      input logic [5:0] es, input logic ef, input logic [31:0] ep, input logic ee);
    exp_t e;
    rst = r; stallreq_id = id; stallreq_ex = ex; mem_req = req; mem_ack = ack;
    branch_flag_i = br; branch_target_i = tgt;
    exp_q.push_back('{stall: es, flush: ef, pc: ep, err: ee});
    #4;
    e = exp_q.pop_front();
    chk({tag, ".stall"}, {26'd0, stall}, {26'd0, e.stall});
    chk({tag, ".flush"}, {31'd0, flush}, {31'd0, e.flush});
    chk({tag, ".new_pc"}, new_pc, e.pc);
    chk({tag, ".mem_err"}, {31'd0, mem_err}, {31'd0, e.err});
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1; stallreq_id = 0; stallreq_ex = 0; mem_req = 0; mem_ack = 0;
    branch_flag_i = 0; branch_target_i = 0;
    @(posedge clk);
    #1;
    step("reset", 1, 0, 0, 0, 0, 0, 32'h0, 6'h00, 0, 32'h0, 0);
`ifdef PIPE_PERF_EN
    chk("reset.stall_cnt", stall_cnt, 32'd0);
    chk("reset.flush_cnt", flush_cnt, 32'd0);
`endif
    step("rw_c0", 0, 0, 0, 1, 0, 0, 32'h0, 6'h1f, 0, 32'h0, 0);
    step("rw_c1", 0, 0, 0, 1, 0, 0, 32'h0, 6'h1f, 0, 32'h0, 0);
    step("rw_c2", 0, 0, 0, 1, 0, 0, 32'h0, 6'h1f, 0, 32'h0, 0);
    step("rw_rst", 1, 0, 0, 0, 0, 0, 32'h0, 6'h00, 0, 32'h0, 0);
    for (int i = 0; i < 5; i++)
      step("rw_after", 0, 0, 0, 0, 0, 0, 32'h0, 6'h00, 0, 32'h0, 0);
    step("zw_ack", 0, 0, 0, 1, 1, 0, 32'h0, 6'h00, 0, 32'h0, 0);
    step("zw_idle", 0, 0, 0, 0, 0, 0, 32'h0, 6'h00, 0, 32'h0, 0);
    step("mw_c1", 0, 0, 0, 1, 0, 0, 32'h0, 6'h1f, 0, 32'h0, 0);
    step("mw_c2", 0, 0, 0, 1, 0, 0, 32'h0, 6'h1f, 0, 32'h0, 0);
    step("mw_ack", 0, 0, 0, 1, 1, 0, 32'h0, 6'h1f, 0, 32'h0, 0);
    step("mw_done", 0, 0, 0, 0, 0, 0, 32'h0, 6'h00, 0, 32'h0, 0);
    step("pri_idex", 0, 1, 1, 0, 0, 0, 32'h0, 6'h0f, 0, 32'h0, 0);
    step("pri_mem", 0, 1, 1, 1, 0, 0, 32'h0, 6'h1f, 0, 32'h0, 0);
    step("pri_wait", 0, 1, 1, 0, 1, 0, 32'h0, 6'h1f, 0, 32'h0, 0);
    step("pri_id", 0, 1, 0, 0, 0, 0, 32'h0, 6'h07, 0, 32'h0, 0);
    step("br_take", 0, 0, 0, 0, 0, 1, 32'h80, 6'h00, 1, 32'h80, 0);
    step("br_ex0", 0, 0, 1, 0, 0, 1, 32'h80, 6'h0f, 0, 32'h0, 0);
    step("br_ex1", 0, 0, 1, 0, 0, 1, 32'h80, 6'h0f, 0, 32'h0, 0);
    step("br_late", 0, 0, 0, 0, 0, 1, 32'h80, 6'h00, 1, 32'h80, 0);
    step("br_idsq", 0, 1, 0, 0, 0, 1, 32'h1234, 6'h00, 1, 32'h1234, 0);
    step("br_mem", 0, 0, 0, 1, 0, 1, 32'h80, 6'h1f, 0, 32'h0, 0);
    step("br_memw", 0, 0, 0, 0, 1, 1, 32'h80, 6'h1f, 0, 32'h0, 0);
    step("br_after", 0, 0, 0, 0, 0, 1, 32'hdead_beec, 6'h00, 1, 32'hdead_beec, 0);
    step("pre_tmo", 1, 0, 0, 0, 0, 0, 32'h0, 6'h00, 0, 32'h0, 0);
    for (int i = 0; i < 4; i++)
      step("tmo_wait", 0, 0, 0, 1, 0, 0, 32'h0, 6'h1f, 0, 32'h0, 0);
    step("tmo_err", 0, 0, 1, 1, 0, 1, 32'h80, 6'h00, 1, 32'h100, 1);
`ifdef PIPE_PERF_EN
    chk("perf.stall_cnt", stall_cnt, 32'd4);
    chk("perf.flush_cnt", flush_cnt, 32'd1);
`endif
    step("tmo_post", 0, 0, 0, 0, 0, 0, 32'h0, 6'h00, 0, 32'h0, 0);
    step("tmo_idle", 0, 0, 0, 0, 0, 0, 32'h0, 6'h00, 0, 32'h0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
